// File: rtl/pc_trap_sched.sv
// pc_trap_sched
// Collects retired PCs from NUM_HARTS harts and checks each one against a
// good-trap and a bad-trap address. When all harts have reached the good trap,
// or any hart has reached the bad trap, the test is reported as finished.
//
// Each hart has its own 2-entry FIFO. A round-robin arbiter pops at most one
// FIFO per cycle into a single registered compare stage. The pass/fail flags
// are updated from that stage on the following edge.
//
// Ports
//   clk, rst                      clock; synchronous active-high reset
//   good_trap_vld/good_trap_pc    good-trap address (static after reset)
//   bad_trap_vld/bad_trap_pc      bad-trap address (static after reset)
//   ret_vld[h], ret_pc[64h+:64]   per-hart retire strobe and PC
//   ret_rdy[h]                    per-hart FIFO not full
//   good_mask[h]                  sticky: hart h reached the good trap
//   all_good, bad_hit, done       pass flag, sticky fail flag, end of test
//   bad_hart                      index of the first hart that hit the bad trap
//   overflow[h]                   sticky: a retire event from hart h was dropped
//   timeout[h]                    only with PC_TRAP_SCHED_TIMEOUT_EN: hart h
//                                 made no retire push for TIMEOUT_CYCLES cycles
//
// Optional feature macro: PC_TRAP_SCHED_TIMEOUT_EN (per-hart watchdog).
module pc_trap_sched #(
    parameter int          NUM_HARTS      = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     good_trap_vld,
    input  logic [63:0]              good_trap_pc,
    input  logic                     bad_trap_vld,
    input  logic [63:0]              bad_trap_pc,
    input  logic [NUM_HARTS-1:0]     ret_vld,
    input  logic [64*NUM_HARTS-1:0]  ret_pc,
    output logic [NUM_HARTS-1:0]     ret_rdy,
    output logic [NUM_HARTS-1:0]     good_mask,
    output logic                     all_good,
    output logic                     bad_hit,
    output logic                     done,
    output logic [3:0]               bad_hart,
`ifdef PC_TRAP_SCHED_TIMEOUT_EN
    output logic [NUM_HARTS-1:0]     timeout,
`endif
    output logic [NUM_HARTS-1:0]     overflow
);

    localparam int IW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

    logic [1:0]           r_cnt  [NUM_HARTS];
    logic                 r_wp   [NUM_HARTS];
    logic                 r_rp   [NUM_HARTS];
    logic [63:0]          r_mem  [NUM_HARTS][2];
    logic [IW-1:0]        r_ptr;
    logic [NUM_HARTS-1:0] r_ovf;

    logic                 r_stg_vld;
    logic [3:0]           r_stg_hart;
    logic [63:0]          r_stg_pc;

    logic [NUM_HARTS-1:0] r_good_mask;
    logic                 r_bad_hit;
    logic [3:0]           r_bad_hart;

    logic [NUM_HARTS-1:0] w_rdy;
    logic [NUM_HARTS-1:0] w_push;
    logic [NUM_HARTS-1:0] w_pop;
    logic                 w_gnt_vld;
    logic [IW-1:0]        w_gnt_idx;
    logic [63:0]          w_gnt_pc;
    logic [IW:0]          w_rr_sum;
    logic [IW-1:0]        w_rr_idx;
    logic                 w_bad_cmp;
    logic                 w_good_cmp;
    logic                 w_to_any;
    logic                 w_done;

    // Ready comes from the count alone, so a full FIFO refuses even if it is popped this cycle.
    always_comb begin
        w_rdy  = '0;
        w_push = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            w_rdy[h]  = (r_cnt[h] != 2'd2);
            w_push[h] = ret_vld[h] & w_rdy[h];
        end
    end

    // Round-robin arbiter: first non-empty FIFO at or after r_ptr, wrapping modulo NUM_HARTS.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_rr_sum  = '0;
        w_rr_idx  = '0;
        for (int k = 0; k < NUM_HARTS; k++) begin
            w_rr_sum = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_rr_sum >= (IW+1)'(NUM_HARTS)) begin
                w_rr_sum = w_rr_sum - (IW+1)'(NUM_HARTS);
            end else begin
                w_rr_sum = w_rr_sum;
            end
            w_rr_idx = w_rr_sum[IW-1:0];
            if (!w_gnt_vld && (r_cnt[w_rr_idx] != 2'd0)) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_rr_idx;
            end else begin
                w_gnt_vld = w_gnt_vld;
            end
        end
        w_gnt_pc = r_mem[w_gnt_idx][r_rp[w_gnt_idx]];
        w_pop    = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            w_pop[h] = w_gnt_vld && (w_gnt_idx == IW'(h));
        end
    end

    // Per-hart FIFOs, drop flags and the round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                r_cnt[h]    <= 2'd0;
                r_wp[h]     <= 1'b0;
                r_rp[h]     <= 1'b0;
                r_mem[h][0] <= 64'd0;
                r_mem[h][1] <= 64'd0;
            end
            r_ovf <= '0;
            r_ptr <= '0;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (w_push[h]) begin
                    r_mem[h][r_wp[h]] <= ret_pc[64*h +: 64];
                    r_wp[h]           <= ~r_wp[h];
                end
                if (w_pop[h]) begin
                    r_rp[h] <= ~r_rp[h];
                end
                case ({w_push[h], w_pop[h]})
                    2'b10:   r_cnt[h] <= r_cnt[h] + 2'd1;
                    2'b01:   r_cnt[h] <= r_cnt[h] - 2'd1;
                    default: r_cnt[h] <= r_cnt[h];
                endcase
                if (ret_vld[h] && !w_rdy[h]) begin
                    r_ovf[h] <= 1'b1;
                end
            end
            if (w_gnt_vld) begin
                r_ptr <= (w_gnt_idx == IW'(NUM_HARTS - 1)) ? '0 : w_gnt_idx + IW'(1);
            end
        end
    end

    // Compare stage: the granted {valid, hart, PC}.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stg_vld  <= 1'b0;
            r_stg_hart <= 4'd0;
            r_stg_pc   <= 64'd0;
        end else begin
            r_stg_vld  <= w_gnt_vld;
            r_stg_hart <= 4'(w_gnt_idx);
            r_stg_pc   <= w_gnt_pc;
        end
    end

    // A PC matching both traps counts only as a bad hit.
    assign w_bad_cmp  = r_stg_vld & bad_trap_vld & (r_stg_pc == bad_trap_pc);
    assign w_good_cmp = r_stg_vld & good_trap_vld & (r_stg_pc == good_trap_pc) & ~w_bad_cmp;
    assign w_done     = (&r_good_mask) | r_bad_hit | w_to_any;

    // Result flags; they freeze once done is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_good_mask <= '0;
            r_bad_hit   <= 1'b0;
            r_bad_hart  <= 4'd0;
        end else if (!w_done) begin
            if (w_bad_cmp) begin
                r_bad_hit <= 1'b1;
                if (!r_bad_hit) begin
                    r_bad_hart <= r_stg_hart;
                end
            end
            if (w_good_cmp) begin
                r_good_mask[r_stg_hart[IW-1:0]] <= 1'b1;
            end
        end
    end

`ifdef PC_TRAP_SCHED_TIMEOUT_EN
    logic [31:0]          r_to_cnt [NUM_HARTS];
    logic [NUM_HARTS-1:0] r_timeout;

    // Watchdog: cleared by a push, counts idle cycles until done, saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                r_to_cnt[h] <= 32'd0;
            end
            r_timeout <= '0;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (w_push[h]) begin
                    r_to_cnt[h] <= 32'd0;
                end else if (!w_done && (r_to_cnt[h] != TIMEOUT_CYCLES)) begin
                    r_to_cnt[h] <= r_to_cnt[h] + 32'd1;
                    if (r_to_cnt[h] == TIMEOUT_CYCLES - 32'd1) begin
                        r_timeout[h] <= 1'b1;
                    end
                end
            end
        end
    end

    assign w_to_any = |r_timeout;
    assign timeout  = r_timeout;
`else
    assign w_to_any = 1'b0;
`endif

    assign ret_rdy   = w_rdy;
    assign good_mask = r_good_mask;
    assign all_good  = &r_good_mask;
    assign bad_hit   = r_bad_hit;
    assign bad_hart  = r_bad_hart;
    assign done      = w_done;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_pc_trap_sched.sv
module tb_pc_trap_sched;

    localparam int N = 4;
    localparam logic [63:0] GPC  = 64'h0000_0000_8000_1000;
    localparam logic [63:0] BPC  = 64'h0000_0000_DEAD_0000;
    localparam logic [63:0] SPC  = 64'h0000_0000_8000_2000;

    logic           clk = 1'b0;
    logic           rst;
    logic           good_trap_vld;
    logic [63:0]    good_trap_pc;
    logic           bad_trap_vld;
    logic [63:0]    bad_trap_pc;
    logic [N-1:0]   ret_vld;
    logic [64*N-1:0] ret_pc;
    logic [N-1:0]   ret_rdy;
    logic [N-1:0]   good_mask;
    logic           all_good;
    logic           bad_hit;
    logic           done;
    logic [3:0]     bad_hart;
    logic [N-1:0]   overflow;
`ifdef PC_TRAP_SCHED_TIMEOUT_EN
    logic [N-1:0]   timeout;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        gv;
        logic [63:0] gpc;
        logic        bv;
        logic [63:0] bpc;
        int          hart;
        logic [63:0] pc;
        logic [3:0]  emask;
        logic        ebad;
        logic [3:0]  ebh;
        logic        edone;
    } vec_t;

    typedef struct {
        logic [3:0] mask;
        logic       bad;
        logic [3:0] bh;
        logic       done;
    } exp_t;

    vec_t vecs [8];
    exp_t exp_q [$];

    pc_trap_sched #(
        .NUM_HARTS      (N),
        .TIMEOUT_CYCLES (32'd16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .good_trap_vld (good_trap_vld),
        .good_trap_pc  (good_trap_pc),
        .bad_trap_vld  (bad_trap_vld),
        .bad_trap_pc   (bad_trap_pc),
        .ret_vld       (ret_vld),
        .ret_pc        (ret_pc),
        .ret_rdy       (ret_rdy),
        .good_mask     (good_mask),
        .all_good      (all_good),
        .bad_hit       (bad_hit),
        .done          (done),
        .bad_hart      (bad_hart),
`ifdef PC_TRAP_SCHED_TIMEOUT_EN
        .timeout       (timeout),
`endif
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset(input logic gv, input logic [63:0] gpc,
                            input logic bv, input logic [63:0] bpc);
        rst           = 1'b1;
        ret_vld       = '0;
        ret_pc        = '0;
        good_trap_vld = gv;
        good_trap_pc  = gpc;
        bad_trap_vld  = bv;
        bad_trap_pc   = bpc;
        tick();
        chk("reset ret_rdy",   64'(ret_rdy),   64'(4'b1111));
        chk("reset good_mask", 64'(good_mask), 64'(4'b0000));
        chk("reset bad_hit",   64'(bad_hit),   64'(1'b0));
        chk("reset done",      64'(done),      64'(1'b0));
        chk("reset overflow",  64'(overflow),  64'(4'b0000));
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] seqm [6];
        exp_t       e;

        rst = 1'b1;
        ret_vld = '0;
        ret_pc = '0;
        good_trap_vld = 1'b0;
        good_trap_pc = 64'd0;
        bad_trap_vld = 1'b0;
        bad_trap_pc = 64'd0;

        //            gv    gpc  bv    bpc  hart pc                     mask     bad   bh    done
        vecs[0] = '{1'b1, GPC, 1'b1, BPC, 0, GPC,                   4'b0001, 1'b0, 4'd0, 1'b0};
        vecs[1] = '{1'b1, GPC, 1'b1, BPC, 2, GPC,                   4'b0100, 1'b0, 4'd0, 1'b0};
        vecs[2] = '{1'b1, GPC, 1'b1, BPC, 1, BPC,                   4'b0000, 1'b1, 4'd1, 1'b1};
        vecs[3] = '{1'b1, GPC, 1'b1, BPC, 3, 64'h1234_5678,         4'b0000, 1'b0, 4'd0, 1'b0};
        vecs[4] = '{1'b0, GPC, 1'b1, BPC, 0, GPC,                   4'b0000, 1'b0, 4'd0, 1'b0};
        vecs[5] = '{1'b1, GPC, 1'b0, BPC, 3, BPC,                   4'b0000, 1'b0, 4'd0, 1'b0};
        vecs[6] = '{1'b1, SPC, 1'b1, SPC, 1, SPC,                   4'b0000, 1'b1, 4'd1, 1'b1};
        vecs[7] = '{1'b1, GPC, 1'b1, BPC, 3, BPC,                   4'b0000, 1'b1, 4'd3, 1'b1};

        // Single events: push at edge 0, compare stage at edge 1, flags at edge 2.
        for (int i = 0; i < 8; i++) begin
            do_reset(vecs[i].gv, vecs[i].gpc, vecs[i].bv, vecs[i].bpc);
            ret_pc[vecs[i].hart*64 +: 64] = vecs[i].pc;
            ret_vld[vecs[i].hart] = 1'b1;
            exp_q.push_back('{mask: vecs[i].emask, bad: vecs[i].ebad, bh: vecs[i].ebh, done: vecs[i].edone});
            tick();
            ret_vld = '0;
            tick();
            chk($sformatf("vec%0d early mask", i), 64'(good_mask), 64'(4'b0000));
            chk($sformatf("vec%0d early bad", i),  64'(bad_hit),   64'(1'b0));
            tick();
            e = exp_q.pop_front();
            chk($sformatf("vec%0d good_mask", i), 64'(good_mask), 64'(e.mask));
            chk($sformatf("vec%0d bad_hit", i),   64'(bad_hit),   64'(e.bad));
            chk($sformatf("vec%0d bad_hart", i),  64'(bad_hart),  64'(e.bh));
            chk($sformatf("vec%0d done", i),      64'(done),      64'(e.done));
        end

        // All harts retire the good trap on the same cycle: grants 0,1,2,3 in order.
        seqm[0] = 4'b0000; seqm[1] = 4'b0000; seqm[2] = 4'b0001;
        seqm[3] = 4'b0011; seqm[4] = 4'b0111; seqm[5] = 4'b1111;
        do_reset(1'b1, GPC, 1'b1, BPC);
        for (int h = 0; h < N; h++) ret_pc[h*64 +: 64] = GPC;
        ret_vld = 4'b1111;
        for (int k = 0; k < 6; k++) exp_q.push_back('{mask: seqm[k], bad: 1'b0, bh: 4'd0, done: (k == 5)});
        for (int k = 0; k < 6; k++) begin
            tick();
            ret_vld = '0;
            e = exp_q.pop_front();
            chk($sformatf("rr mask c%0d", k), 64'(good_mask), 64'(e.mask));
            chk($sformatf("rr ret_rdy c%0d", k), 64'(ret_rdy), 64'(4'b1111));
            chk($sformatf("rr done c%0d", k), 64'(done), 64'(e.done));
        end
        chk("all_good", 64'(all_good), 64'(1'b1));
        // A bad-trap retire after done must not change the frozen flags.
        ret_pc[0 +: 64] = BPC;
        ret_vld = 4'b0001;
        tick();
        ret_vld = '0;
        tick();
        tick();
        tick();
        chk("frozen bad_hit", 64'(bad_hit), 64'(1'b0));
        chk("frozen mask",    64'(good_mask), 64'(4'b1111));

        // Hart 2 retires three cycles in a row while harts 0 and 1 stay busy.
        do_reset(1'b0, GPC, 1'b0, BPC);
        for (int h = 0; h < N; h++) ret_pc[h*64 +: 64] = 64'h100 + 64'(h);
        ret_vld = 4'b0111;
        tick();
        chk("ovf rdy2 cycle2", 64'(ret_rdy[2]), 64'(1'b1));
        tick();
        chk("ovf rdy2 cycle3", 64'(ret_rdy[2]), 64'(1'b0));
        chk("ovf flag2 before", 64'(overflow[2]), 64'(1'b0));
        tick();
        ret_vld = 4'b0011;
        chk("ovf flag2", 64'(overflow[2]), 64'(1'b1));
        chk("ovf flag3", 64'(overflow[3]), 64'(1'b0));
        tick();
        ret_vld = '0;
        tick();
        chk("ovf rdy3", 64'(ret_rdy[3]), 64'(1'b1));

        // Reset mid-operation with hart 3 full; nothing buffered may survive.
        do_reset(1'b1, GPC, 1'b0, BPC);
        for (int h = 0; h < N; h++) ret_pc[h*64 +: 64] = GPC;
        ret_vld = 4'b1111;
        tick();
        tick();
        ret_vld = '0;
        chk("mid rdy before rst", 64'(ret_rdy), 64'(4'b0001));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid rdy after rst", 64'(ret_rdy), 64'(4'b1111));
        chk("mid mask after rst", 64'(good_mask), 64'(4'b0000));
        tick();
        tick();
        tick();
        chk("mid no stale mask", 64'(good_mask), 64'(4'b0000));
        chk("mid no stale done", 64'(done), 64'(1'b0));
        chk("mid no stale ovf",  64'(overflow), 64'(4'b0000));
        ret_vld = 4'b1001;
        tick();
        ret_vld = '0;
        tick();
        tick();
        chk("post-rst first grant h0", 64'(good_mask), 64'(4'b0001));
        tick();
        chk("post-rst second grant h3", 64'(good_mask), 64'(4'b1001));

`ifdef PC_TRAP_SCHED_TIMEOUT_EN
        // Idle harts: the watchdog must fire within 17 cycles of reset.
        do_reset(1'b1, GPC, 1'b0, BPC);
        for (int k = 0; k < 17 && !timeout[0]; k++) tick();
        chk("timeout[0]", 64'(timeout[0]), 64'(1'b1));
        chk("timeout done", 64'(done), 64'(1'b1));
`endif

        chk("scoreboard empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
